instr_fetch_queue: RTL
======================

Name: instr_fetch_queue

Overview:
Fetch front-end upstream of the single-cycle CPU datapath. It reads big-endian instruction bytes from the byte-wide instruction memory over a req/ack bus and assembles them into 32-bit words. Each word is buffered, together with its PC, in a DEPTH-entry queue. The decode/execute stage consumes the queue through a valid/ready interface and issues redirects for branch, jump and jal.

Parameters:
DEPTH, 4, number of queue entries (power of two, ≥2)
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_req  output  1  byte read request to instruction memory
mem_addr  output  32  byte address, stable while mem_req=1 and mem_ack=0
mem_ack  input  1  request accepted; mem_rdata valid this cycle
mem_rdata  input  8  returned byte
redirect_valid  input  1  one-cycle pulse: flush and restart fetch
redirect_pc  input  32  new fetch address
instr_valid  output  1  queue head valid
instr  output  32  queue head instruction
instr_pc  output  32  byte address of queue head
instr_ready  input  1  consumer accepts head when instr_valid=1
queue_count  output  clog2(DEPTH+1)  current occupancy
misalign_err  output  1  sticky: a redirect_pc with [1:0]≠0 was received

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk. All state updates on the rising edge of clk.
- Reset values: mem_req=0, mem_addr=RESET_PC, instr_valid=0, queue_count=0, misalign_err=0, fetch_pc=RESET_PC, byte_idx=0, FSM=FETCH. Queue contents are don't-care.
- FSM states:
  - FETCH: mem_req=1, mem_addr=fetch_pc+byte_idx.
  - HOLD: mem_req=0. Entered when byte_idx=0 and queue_count=DEPTH. Return to FETCH in the cycle after queue_count<DEPTH.
- A new word (byte_idx=0) starts only when queue_count<DEPTH. Because only this block pushes, a started word always finds space at completion, so overflow cannot occur.
- Byte capture: on mem_ack, store the byte in the assembly register and increment byte_idx.
  - idx0 goes to [31:24], idx1 to [23:16], idx2 to [15:8], idx3 to [7:0].
  - mem_ack may arrive in the same cycle as mem_req.
  - With mem_ack tied high, throughput is 1 word per 4 cycles.
- Word completion: on the ack for idx3, push {assembled word, fetch_pc} at the next edge, set fetch_pc += 4 (wraps modulo 2^32) and set byte_idx=0.
  - instr_valid rises the cycle after the 4th ack.
  - First-word latency after reset release, with mem_ack=1: instr_valid=1 after the 4th rising edge.
- Queue: instr, instr_pc and instr_valid are driven combinationally from the head entry.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - instr_ready while empty has no effect.
- Redirect (highest priority over all other events in that cycle):
  - Flush the queue: count=0, pointers=0, instr_valid=0 next cycle.
  - Abort the partial word: byte_idx=0. Any byte acked in the same cycle is discarded.
  - A pop in the same cycle is discarded.
  - fetch_pc = {redirect_pc[31:2], 2'b00}. FSM=FETCH.
  - If redirect_pc[1:0]≠0, set misalign_err=1 (cleared only by reset).
- A redirect on consecutive cycles: the last one wins.
- Reset asserted mid-word or while full: all state returns to reset values immediately (asynchronously).
- mem_addr must not change while mem_req=1 and mem_ack=0, except on redirect, which may abandon the request (mem_req may drop).

Decomposition:
- Shared package fetch_pkg holds:
  - FSM state enum (FETCH, HOLD)
  - INSTR_W=32 and BYTE_W=8
  - RESET_PC default
  - a struct pairing an instruction with its PC
- One sub-module, sync_fifo: a parameterised-width/depth FIFO with flush, instantiated with width 64. The FSM, byte assembler and PC logic stay in the top module.

Test Plan:
1. Memory preloaded with bytes 8C,01,00,04,AC,02,00,08 at address 0; mem_ack=1; instr_ready=1 → instr=32'h8C010004 with pc 0, then 32'hAC020008 with pc 4; first instr_valid after the 4th edge.
2. instr_ready=0, mem_ack=1 → queue_count reaches DEPTH=4 and mem_req=0 (HOLD). Pulse instr_ready for one cycle → count 3, mem_req=1 the next cycle, and the pops return words in order with pcs 0,4,8,12.
3. Redirect to 32'h40 after byte 2 of a word has been acked, with ack in the same cycle → queue empty next cycle, mem_addr=32'h40, the next valid instr has pc 32'h40, and no partial word leaks out.
4. redirect_pc=32'h23 → fetch restarts at 32'h20 and misalign_err=1 stays set until reset.
5. Randomised mem_ack stalls (0–5 cycles per byte) against a 16-word image → output sequence identical to the zero-stall run, and mem_addr is stable during every stall.
6. Reset asserted while the queue is full and a word is mid-assembly → instr_valid, mem_req and queue_count are 0 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int BYTE_W  = 8;
  localparam logic [INSTR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
  } instr_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is presented combinationally.
module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            pop_data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              pop_fire, push_fire;

  assign valid     = (count != '0);
  assign pop_fire  = pop && valid;
  assign push_fire = push && ((count != CNT_W'(DEPTH)) || pop_fire);
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_fire && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Byte-serial instruction fetch: assembles big-endian words and queues them with their PC.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       mem_req,
  output logic [INSTR_W-1:0]         mem_addr,
  input  logic                       mem_ack,
  input  logic [BYTE_W-1:0]          mem_rdata,
  input  logic                       redirect_valid,
  input  logic [INSTR_W-1:0]         redirect_pc,
  output logic                       instr_valid,
  output logic [INSTR_W-1:0]         instr,
  output logic [INSTR_W-1:0]         instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       misalign_err
);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_state_t                  state, state_nxt;
  logic [INSTR_W-1:0]            fetch_pc;
  logic [1:0]                    byte_idx;
  logic [INSTR_W-BYTE_W-1:0]     asm_word;
  logic                          byte_fire, word_done, push, pop_fire;
  logic [CNT_W-1:0]              count_after;
  instr_entry_t                  push_entry, head_entry;

  // Reset gates the request so it drops the instant reset is asserted.
  assign mem_req     = (state == FETCH) && !reset;
  assign mem_addr    = fetch_pc + {{(INSTR_W-2){1'b0}}, byte_idx};
  assign byte_fire   = mem_req && mem_ack;
  assign word_done   = byte_fire && (byte_idx == 2'd3);
  assign push        = word_done && !redirect_valid;
  assign pop_fire    = instr_valid && instr_ready;
  assign count_after = queue_count + CNT_W'(1) - CNT_W'(pop_fire);
  assign push_entry  = '{instr: {asm_word, mem_rdata}, pc: fetch_pc};

  assign instr    = head_entry.instr;
  assign instr_pc = head_entry.pc;

  // A word completing into the last free slot parks the fetcher, so the
  // next word can never start without space for it.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (word_done && (count_after == CNT_W'(DEPTH))) state_nxt = HOLD;
      HOLD:    if (queue_count < CNT_W'(DEPTH)) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
    if (redirect_valid) state_nxt = FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      fetch_pc     <= RESET_PC;
      byte_idx     <= 2'd0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[INSTR_W-1:2], 2'b00};
        byte_idx <= 2'd0;
        if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      end else if (byte_fire) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  // Upper three bytes are held here; the fourth goes straight into the queue.
  always_ff @(posedge clk) begin
    if (byte_fire) begin
      case (byte_idx)
        2'd0:    asm_word[23:16] <= mem_rdata;
        2'd1:    asm_word[15:8]  <= mem_rdata;
        2'd2:    asm_word[7:0]   <= mem_rdata;
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .DATA_W (2*INSTR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (instr_ready),
    .pop_data  (head_entry),
    .valid     (instr_valid),
    .count     (queue_count)
  );
endmodule
